fir_bank_output_stage: RTL and testbench

//  Downstream stage of the 8-channel FIR bank. Captures the 8 signed 43-bit accumulator results when the

---
 rtl/fir_bank_output_stage.sv | 199 +++++++++++++++++++
 tb/tb_fir_bank_output_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_bank_output_stage.sv
// ---------------------------------------------------------------------------
// fir_bank_output_stage
//
// Output stage of the 8-channel FIR bank. When the bank strobes acc_valid,
// the full set of signed accumulators is captured. One cycle later every
// channel is rounded, scaled down by SHIFT bits and saturated to OUT_W bits.
// The results are presented as a registered parallel word (par_out with a
// par_valid pulse) and are also streamed, channel 0 first, over a
// valid/ready interface. A result set that arrives while the previous one
// is still being processed or streamed is dropped, and the sticky overrun
// flag is raised.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   acc_in     in   NCH packed signed accumulators, channel k at [k*ACC_W +: ACC_W]
//   acc_valid  in   one-cycle strobe, acc_in holds a complete set
//   ovr_clr    in   clears the sticky overrun flag (a simultaneous drop wins)
//   par_out    out  NCH packed signed results, channel k at [k*OUT_W +: OUT_W]
//   par_valid  out  one-cycle pulse, par_out has just been updated
//   sat_flags  out  bit k = channel k saturated in the latest set
//   m_data     out  stream sample (signed)
//   m_chan     out  channel index of m_data
//   m_valid    out  stream valid
//   m_ready    in   stream ready
//   overrun    out  sticky, a result set was dropped
// ---------------------------------------------------------------------------
module fir_bank_output_stage #(
    parameter int NCH   = 8,
    parameter int ACC_W = 43,
    parameter int OUT_W = 16,
    parameter int SHIFT = 26,
    parameter int ROUND = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NCH*ACC_W-1:0] acc_in,
    input  logic                 acc_valid,
    input  logic                 ovr_clr,
    output logic [NCH*OUT_W-1:0] par_out,
    output logic                 par_valid,
    output logic [NCH-1:0]       sat_flags,
    output logic [OUT_W-1:0]     m_data,
    output logic [2:0]           m_chan,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun
);

    // One extra bit so that adding the rounding constant to the most
    // positive accumulator cannot wrap.
    localparam int EXT_W = ACC_W + 1;
    localparam int MAX_I = (2 ** (OUT_W - 1)) - 1;
    localparam int MIN_I = -(2 ** (OUT_W - 1));

    localparam logic signed [EXT_W-1:0] RND_S =
        (ROUND != 0) ? (EXT_W'(1) << (SHIFT - 1)) : EXT_W'(0);
    localparam logic signed [EXT_W-1:0] MAX_S = EXT_W'(MAX_I);
    localparam logic signed [EXT_W-1:0] MIN_S = EXT_W'(MIN_I);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SEND
    } state_t;

    state_t                 state_q, state_d;
    logic [NCH*ACC_W-1:0]   hold_q;
    logic [NCH*OUT_W-1:0]   par_q, par_d;
    logic [NCH-1:0]         sat_q, sat_d;
    logic                   par_valid_q, par_valid_d;
    logic [2:0]             chan_q, chan_d;
    logic                   m_valid_q, m_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   capture;
    logic                   drop;

    logic [NCH*OUT_W-1:0]   conv;
    logic [NCH-1:0]         conv_sat;

    // ---------------------------------------------------------------------
    // Parallel conversion of all captured channels.
    // ---------------------------------------------------------------------
    always_comb begin
        logic signed [EXT_W-1:0] acc_ext;
        logic signed [EXT_W-1:0] t;
        logic signed [EXT_W-1:0] s;
        // NOTE: every variable written here gets a value before any branch,
        // so no path can leave one unassigned and infer a latch.
        conv     = '0;
        conv_sat = '0;
        acc_ext  = '0;
        t        = '0;
        s        = '0;
        for (int k = 0; k < NCH; k++) begin
            acc_ext = {hold_q[k*ACC_W + ACC_W - 1], hold_q[k*ACC_W +: ACC_W]};
            t       = acc_ext + RND_S;
            s       = t >>> SHIFT;
            if (s > MAX_S) begin
                conv[k*OUT_W +: OUT_W] = OUT_W'(MAX_I);
                conv_sat[k]            = 1'b1;
            end else if (s < MIN_S) begin
                conv[k*OUT_W +: OUT_W] = OUT_W'(MIN_I);
                conv_sat[k]            = 1'b1;
            end else begin
                conv[k*OUT_W +: OUT_W] = s[OUT_W-1:0];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and output logic.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        par_d       = par_q;
        sat_d       = sat_q;
        par_valid_d = 1'b0;
        chan_d      = chan_q;
        m_valid_d   = m_valid_q;
        capture     = 1'b0;

        case (state_q)
            IDLE: begin
                if (acc_valid) begin
                    capture = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                par_d       = conv;
                sat_d       = conv_sat;
                par_valid_d = 1'b1;
                m_valid_d   = 1'b1;
                chan_d      = 3'd0;
                state_d     = SEND;
            end
            SEND: begin
                // m_valid is always high in SEND, so m_ready alone marks a transfer.
                if (m_ready) begin
                    if (chan_q == 3'(NCH - 1)) begin
                        m_valid_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        chan_d = chan_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Any set arriving outside IDLE is lost, including the cycle in which
        // SEND hands back to IDLE. A drop overrides a simultaneous clear.
        drop      = acc_valid && (state_q != IDLE);
        overrun_d = drop || (overrun_q && !ovr_clr);
    end

    // ---------------------------------------------------------------------
    // State registers.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the values from before this edge.
        if (reset) begin
            state_q     <= IDLE;
            par_q       <= '0;
            sat_q       <= '0;
            par_valid_q <= 1'b0;
            chan_q      <= 3'd0;
            m_valid_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            par_q       <= par_d;
            sat_q       <= sat_d;
            par_valid_q <= par_valid_d;
            chan_q      <= chan_d;
            m_valid_q   <= m_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // NOTE: the holding registers are pure data with no reset; they are only
    // read in CALC, which is reachable only after a fresh capture.
    always_ff @(posedge clock) begin
        if (capture) begin
            hold_q <= acc_in;
        end
    end

    assign par_out   = par_q;
    assign par_valid = par_valid_q;
    assign sat_flags = sat_q;
    assign m_data    = par_q[int'(chan_q)*OUT_W +: OUT_W];
    assign m_chan    = chan_q;
    assign m_valid   = m_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fir_bank_output_stage.sv
// ---------------------------------------------------------------------------
// tb_fir_bank_output_stage
//
// Directed and randomized stimulus for fir_bank_output_stage. Expected
// results come from an arithmetic reference model (round half up, floor
// division by 2^26, clamp to 16 bits). Inputs are driven and outputs
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fir_bank_output_stage;

    localparam int NCH   = 8;
    localparam int ACC_W = 43;
    localparam int OUT_W = 16;

    logic                 clock;
    logic                 reset;
    logic [NCH*ACC_W-1:0] acc_in;
    logic                 acc_valid;
    logic                 ovr_clr;
    logic [NCH*OUT_W-1:0] par_out;
    logic                 par_valid;
    logic [NCH-1:0]       sat_flags;
    logic [OUT_W-1:0]     m_data;
    logic [2:0]           m_chan;
    logic                 m_valid;
    logic                 m_ready;
    logic                 overrun;

    int vectors     = 0;
    int miscompares = 0;

    longint     set_acc [NCH];
    logic [15:0] exp_res [NCH];
    logic        exp_sat [NCH];

    fir_bank_output_stage dut (
        .clock     (clock),
        .reset     (reset),
        .acc_in    (acc_in),
        .acc_valid (acc_valid),
        .ovr_clr   (ovr_clr),
        .par_out   (par_out),
        .par_valid (par_valid),
        .sat_flags (sat_flags),
        .m_data    (m_data),
        .m_chan    (m_chan),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .overrun   (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: round half up, floor-divide by 2^26, clamp to int16.
    function automatic void ref_conv(input longint acc, output logic [15:0] res, output logic sat);
        longint d;
        longint t;
        longint q;
        d = longint'(1) << 26;
        t = acc + (longint'(1) << 25);
        q = t / d;
        if ((t % d) != 0 && t < 0) q = q - 1;
        if (q > 32767) begin
            res = 16'h7fff;
            sat = 1'b1;
        end else if (q < -32768) begin
            res = 16'h8000;
            sat = 1'b1;
        end else begin
            res = q[15:0];
            sat = 1'b0;
        end
    endfunction

    function automatic longint rand_acc();
        longint r;
        r = longint'({$urandom(), $urandom()});
        return r >>> (21 + $urandom_range(0, 12));
    endfunction

    task automatic fill_random();
        for (int k = 0; k < NCH; k++) set_acc[k] = rand_acc();
    endtask

    task automatic drive_set();
        for (int k = 0; k < NCH; k++) acc_in[k*ACC_W +: ACC_W] = set_acc[k][ACC_W-1:0];
    endtask

    task automatic check_par(input string tag);
        logic [NCH-1:0] s;
        for (int k = 0; k < NCH; k++) begin
            check($sformatf("%s_par_ch%0d", tag, k), 64'(par_out[k*OUT_W +: OUT_W]), 64'(exp_res[k]));
            s[k] = exp_sat[k];
        end
        check({tag, "_sat"}, 64'(sat_flags), 64'(s));
    endtask

    // Present a set in IDLE and check the parallel result one edge after capture.
    task automatic start_set(input string tag);
        for (int k = 0; k < NCH; k++) ref_conv(set_acc[k], exp_res[k], exp_sat[k]);
        @(negedge clock);
        drive_set();
        acc_valid = 1'b1;
        @(negedge clock);
        acc_valid = 1'b0;
        check({tag, "_pv_early"}, 64'(par_valid), 64'd0);
        @(negedge clock);
        check({tag, "_pv"}, 64'(par_valid), 64'd1);
        check({tag, "_mvalid"}, 64'(m_valid), 64'd1);
        check({tag, "_mchan0"}, 64'(m_chan), 64'd0);
        check_par(tag);
    endtask

    // Receive the stream. ready_mode 0: always ready; 1: pattern 1,0,0,1.
    // drop_at: stream position at which a second set is strobed (-1 none);
    // clr_with_drop: assert ovr_clr in that same cycle.
    task automatic stream(input string tag, input int ready_mode, input int drop_at,
                          input bit clr_with_drop);
        int          count = 0;
        int          cycles = 0;
        bit          stalled = 1'b0;
        bit          dropped = 1'b0;
        logic [15:0] held_data = '0;
        logic [2:0]  held_chan = '0;
        logic        r;
        while (count < NCH && cycles < 200) begin
            check($sformatf("%s_mv_c%0d", tag, cycles), 64'(m_valid), 64'd1);
            if (stalled) begin
                check($sformatf("%s_hold_data_c%0d", tag, cycles), 64'(m_data), 64'(held_data));
                check($sformatf("%s_hold_chan_c%0d", tag, cycles), 64'(m_chan), 64'(held_chan));
            end
            r = (ready_mode == 0) || (cycles % 4 == 0) || (cycles % 4 == 3);
            m_ready = r;
            if (count == drop_at && !dropped) begin
                for (int k = 0; k < NCH; k++)
                    acc_in[k*ACC_W +: ACC_W] = ACC_W'(rand_acc());
                acc_valid = 1'b1;
                ovr_clr   = clr_with_drop;
                dropped   = 1'b1;
            end
            if (r) begin
                check($sformatf("%s_chan%0d", tag, count), 64'(m_chan), 64'(count));
                check($sformatf("%s_data%0d", tag, count), 64'(m_data), 64'(exp_res[count]));
                count++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                held_data = m_data;
                held_chan = m_chan;
            end
            @(negedge clock);
            acc_valid = 1'b0;
            ovr_clr   = 1'b0;
            cycles++;
            if (cycles == 1) check({tag, "_pv_pulse"}, 64'(par_valid), 64'd0);
        end
        check({tag, "_transfers"}, 64'(count), 64'(NCH));
        m_ready = 1'b0;
        check({tag, "_mv_end"}, 64'(m_valid), 64'd0);
        @(negedge clock);
        check({tag, "_idle_pv"}, 64'(par_valid), 64'd0);
        check({tag, "_idle_mv"}, 64'(m_valid), 64'd0);
        check_par({tag, "_after"});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_par_out"}, 64'(par_out == '0), 64'd1);
        check({tag, "_par_valid"}, 64'(par_valid), 64'd0);
        check({tag, "_sat"}, 64'(sat_flags), 64'd0);
        check({tag, "_m_data"}, 64'(m_data), 64'd0);
        check({tag, "_m_chan"}, 64'(m_chan), 64'd0);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_overrun"}, 64'(overrun), 64'd0);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        acc_in    = '0;
        acc_valid = 1'b0;
        ovr_clr   = 1'b0;
        m_ready   = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_state("rst");
        reset = 1'b0;

        // T1: exact multiples of 2^26.
        for (int k = 0; k < NCH; k++) set_acc[k] = longint'(k + 1) << 26;
        start_set("t1");
        stream("t1", 0, -1, 1'b0);
        check("t1_overrun", 64'(overrun), 64'd0);

        // T2: rounding boundaries.
        set_acc[0] = longint'(1) << 25;
        set_acc[1] = (longint'(1) << 25) - 1;
        set_acc[2] = -(longint'(1) << 25);
        set_acc[3] = -(longint'(1) << 25) - 1;
        set_acc[4] = longint'(3) << 25;
        set_acc[5] = -(longint'(3) << 25);
        set_acc[6] = 0;
        set_acc[7] = -(longint'(5) << 26);
        start_set("t2");
        stream("t2", 0, -1, 1'b0);

        // T3: saturation boundaries.
        set_acc[0] = (longint'(1) << 42) - 1;
        set_acc[1] = -(longint'(1) << 42);
        set_acc[2] = longint'(32767) << 26;
        set_acc[3] = (longint'(32767) << 26) + (longint'(1) << 25);
        set_acc[4] = -(longint'(32768) << 26) - (longint'(1) << 25);
        set_acc[5] = -(longint'(32768) << 26) - (longint'(1) << 25) - 1;
        set_acc[6] = (longint'(32767) << 26) + (longint'(1) << 25) - 1;
        set_acc[7] = rand_acc();
        start_set("t3");
        stream("t3", 0, -1, 1'b0);

        // T4: back-pressure pattern.
        fill_random();
        start_set("t4");
        stream("t4", 1, -1, 1'b0);

        // T5: drops during SEND, clear, clear together with a drop.
        fill_random();
        start_set("t5a");
        stream("t5a", 0, 3, 1'b0);
        check("t5a_overrun", 64'(overrun), 64'd1);
        ovr_clr = 1'b1;
        @(negedge clock);
        ovr_clr = 1'b0;
        check("t5_cleared", 64'(overrun), 64'd0);
        fill_random();
        start_set("t5b");
        stream("t5b", 0, NCH - 1, 1'b1);
        check("t5b_overrun", 64'(overrun), 64'd1);

        // Randomized sets with back-pressure and occasional drops.
        for (int i = 0; i < 4; i++) begin
            fill_random();
            start_set($sformatf("rnd%0d", i));
            stream($sformatf("rnd%0d", i), i % 2, (i == 2) ? int'($urandom_range(0, NCH - 1)) : -1, 1'b0);
        end

        // T6: reset in the middle of the stream.
        fill_random();
        start_set("t6");
        m_ready = 1'b1;
        n = 0;
        while (m_chan != 3'd3 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("t6_reached_ch3", 64'(m_chan), 64'd3);
        reset   = 1'b1;
        m_ready = 1'b0;
        @(negedge clock);
        check_reset_state("t6_rst");
        reset = 1'b0;
        fill_random();
        start_set("t6b");
        stream("t6b", 0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
